// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command-line response receiver.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } sd_resp_state_t;

  localparam logic [6:0] SD_CRC7_POLY    = 7'h09;
  localparam int         SD_RESP_R1_BITS = 48;

endpackage

// File: rtl/sd_crc7_ser.sv
// Serial CRC7 (x^7 + x^3 + 1), initial value 0, one message bit per bit_en.
module sd_crc7_ser
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    crc_d = crc_q;
    fb    = bit_in ^ crc_q[6];
    if (clear) begin
      crc_d = '0;
    end else if (bit_en) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: start-bit hunt, MSB-first capture, framing and CRC7 check.
// Define SD_RESP_CRC_EN to build the CRC7 checker; otherwise crc_err is tied 0.
module sd_resp_rx
  import sd_pkg::*;
#(
  parameter int RESP_BITS       = SD_RESP_R1_BITS,
  parameter int TIMEOUT_STROBES = 64
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 sample_en,
  input  logic                 cmd_in,
  input  logic                 arm,
  input  logic                 resp_ack,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_valid,
  output logic                 crc_err,
  output logic                 frame_err,
  output logic                 timeout,
  output logic                 busy,
  output sd_resp_state_t       state_dbg
);

  // Handshake: resp_valid stays high in DONE with resp_data and the error
  // flags frozen; the response is consumed on the edge where resp_ack is high.

  localparam int CW = $clog2(RESP_BITS + 1);
  localparam int TW = $clog2(TIMEOUT_STROBES + 1);

  sd_resp_state_t       state_q, state_d;
  logic [RESP_BITS-1:0] data_q, data_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]        strobe_cnt_q, strobe_cnt_d;
  logic                 timeout_q, timeout_d;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    bit_cnt_d    = bit_cnt_q;
    strobe_cnt_d = strobe_cnt_q;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d      = WAIT;
          strobe_cnt_d = '0;
          bit_cnt_d    = '0;
        end
      end
      WAIT: begin
        if (sample_en) begin
          if (!cmd_in) begin
            state_d   = RECV;
            data_d    = {data_q[RESP_BITS-2:0], 1'b0};
            bit_cnt_d = CW'(1);
          end else begin
            strobe_cnt_d = strobe_cnt_q + TW'(1);
            if (strobe_cnt_q + TW'(1) == TW'(TIMEOUT_STROBES)) begin
              timeout_d = 1'b1;
              state_d   = IDLE;
            end
          end
        end
      end
      RECV: begin
        if (sample_en) begin
          data_d    = {data_q[RESP_BITS-2:0], cmd_in};
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(RESP_BITS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        // A fresh arm alongside the ack chains straight into the next wait.
        if (resp_ack) begin
          if (arm) begin
            state_d      = WAIT;
            strobe_cnt_d = '0;
            bit_cnt_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      bit_cnt_q    <= '0;
      strobe_cnt_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      bit_cnt_q    <= bit_cnt_d;
      strobe_cnt_q <= strobe_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign resp_data  = data_q;
  assign resp_valid = (state_q == DONE);
  assign frame_err  = (state_q == DONE) && (data_q[RESP_BITS-2] || !data_q[0]);
  assign timeout    = timeout_q;
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;

`ifdef SD_RESP_CRC_EN
  logic       crc_clear, crc_bit_en;
  logic [6:0] crc_w;

  // CRC covers start bit through the last payload bit, not the CRC/end byte.
  assign crc_clear  = arm && ((state_q == IDLE) || ((state_q == DONE) && resp_ack));
  assign crc_bit_en = sample_en &&
                      (((state_q == WAIT) && !cmd_in) ||
                       ((state_q == RECV) && (bit_cnt_q < CW'(RESP_BITS - 8))));

  sd_crc7_ser u_crc7 (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (crc_clear),
    .bit_en(crc_bit_en),
    .bit_in(cmd_in),
    .crc   (crc_w)
  );

  assign crc_err = (state_q == DONE) && (data_q[7:1] != crc_w);
`else
  assign crc_err = 1'b0;
`endif

endmodule
